// File: rtl/vm_video_page_engine_pkg.sv
// Shared definitions for the VM video-page opcodes: command encodings, page aliases,
// framebuffer geometry and the page-to-byte-address mapping.
package vm_video_page_engine_pkg;

  localparam int unsigned PAGE_BYTES = 32000;
  localparam int unsigned ADDR_W     = 17;
  localparam int unsigned OFF_W      = 15;

  localparam logic [OFF_W-1:0] OFF_LAST   = OFF_W'(PAGE_BYTES - 1);
  localparam logic [7:0]       PAGE_FRONT = 8'hFE;
  localparam logic [7:0]       PAGE_BACK  = 8'hFF;

  typedef enum logic [1:0] {
    OP_SELECT = 2'd0,
    OP_FILL   = 2'd1,
    OP_COPY   = 2'd2,
    OP_BLIT   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_COPY_RD,
    ST_COPY,
    ST_COPY_LAST
  } state_e;

  function automatic logic [ADDR_W-1:0] page_base(input logic [1:0] page);
    return ADDR_W'(page) * ADDR_W'(PAGE_BYTES);
  endfunction

endpackage

// File: rtl/vm_video_page_engine_if.sv
// CPU command handshake plus framebuffer RAM port of the video-page engine.
interface vm_video_page_engine_if;

  logic                                        cmd_valid;
  logic                                        cmd_ready;
  logic [1:0]                                  cmd_op;
  logic [7:0]                                  cmd_a;
  logic [7:0]                                  cmd_b;
  logic [vm_video_page_engine_pkg::ADDR_W-1:0] mem_raddr;
  logic [7:0]                                  mem_rdata;
  logic [vm_video_page_engine_pkg::ADDR_W-1:0] mem_waddr;
  logic [7:0]                                  mem_wdata;
  logic                                        mem_we;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, mem_rdata,
    input  cmd_ready, mem_raddr, mem_waddr, mem_wdata, mem_we
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, mem_rdata,
    output cmd_ready, mem_raddr, mem_waddr, mem_wdata, mem_we
  );

endinterface

// File: rtl/vm_video_page_engine_resolve.sv
// Maps a page operand to a physical page: 0xFE is the front page, 0xFF the back page,
// anything else uses its low two bits.
module vm_page_resolve
  import vm_video_page_engine_pkg::*;
(
  input  logic [7:0] i_page,
  input  logic [1:0] i_front,
  input  logic [1:0] i_back,
  output logic [1:0] o_page
);

  always_comb begin
    o_page = i_page[1:0];
    if (i_page == PAGE_FRONT) begin
      o_page = i_front;
    end else if (i_page == PAGE_BACK) begin
      o_page = i_back;
    end
  end

endmodule

// File: rtl/vm_video_page_engine.sv
// Executes select/fill/copy/blit video-page commands, owns the work/front/back pointers
// and streams fills and page copies into the external 4-page framebuffer RAM.
module vm_video_page_engine
  import vm_video_page_engine_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  vm_video_page_engine_if.slave bus,
  output logic [1:0]            front_page,
  output logic [1:0]            work_page,
  output logic                  blit_pulse
);

  state_e            r_state, w_state;
  logic [1:0]        r_work, w_work;
  logic [1:0]        r_front, w_front;
  logic [1:0]        r_back, w_back;
  logic [ADDR_W-1:0] r_raddr, w_raddr;
  logic [ADDR_W-1:0] r_waddr, w_waddr;
  logic [OFF_W-1:0]  r_off, w_off;
  logic [7:0]        r_fill, w_fill;
  logic              r_copy, w_copy;
  logic              r_we, w_we;
  logic              r_ready, w_ready;
  logic              r_blit, w_blit;
  logic [1:0]        w_res_a, w_res_b;

  vm_page_resolve u_res_a (
    .i_page  (bus.cmd_a),
    .i_front (r_front),
    .i_back  (r_back),
    .o_page  (w_res_a)
  );

  vm_page_resolve u_res_b (
    .i_page  (bus.cmd_b),
    .i_front (r_front),
    .i_back  (r_back),
    .o_page  (w_res_b)
  );

  always_comb begin
    w_state = r_state;
    w_work  = r_work;
    w_front = r_front;
    w_back  = r_back;
    w_raddr = r_raddr;
    w_waddr = r_waddr;
    w_off   = r_off;
    w_fill  = r_fill;
    w_copy  = r_copy;
    w_we    = r_we;
    w_ready = r_ready;
    w_blit  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_we    = 1'b0;
        w_ready = 1'b1;
        if (bus.cmd_valid) begin
          case (op_e'(bus.cmd_op))
            OP_SELECT: w_work = w_res_a;
            OP_BLIT: begin
              w_blit = 1'b1;
              if (bus.cmd_a == PAGE_BACK) begin
                w_front = r_back;
                w_back  = r_front;
              end else if (bus.cmd_a != PAGE_FRONT) begin
                w_front = w_res_a;
              end
            end
            OP_FILL: begin
              w_state = ST_FILL;
              w_we    = 1'b1;
              w_ready = 1'b0;
              w_waddr = page_base(w_res_a);
              w_off   = '0;
              w_fill  = {bus.cmd_b[3:0], bus.cmd_b[3:0]};
              w_copy  = 1'b0;
            end
            OP_COPY: begin
              // Both pages are latched now; the destination address sits idle until COPY.
              w_state = ST_COPY_RD;
              w_ready = 1'b0;
              w_raddr = page_base(w_res_a);
              w_waddr = page_base(w_res_b);
              w_off   = '0;
              w_copy  = 1'b1;
            end
            default: w_state = ST_IDLE;
          endcase
        end
      end
      ST_FILL: begin
        if (r_off == OFF_LAST) begin
          w_state = ST_IDLE;
          w_we    = 1'b0;
          w_ready = 1'b1;
        end else begin
          w_off   = r_off + OFF_W'(1);
          w_waddr = r_waddr + ADDR_W'(1);
        end
      end
      ST_COPY_RD: begin
        w_state = ST_COPY;
        w_we    = 1'b1;
        w_raddr = r_raddr + ADDR_W'(1);
        w_off   = r_off + OFF_W'(1);
      end
      ST_COPY: begin
        // r_off tracks the read side; the write side trails it by one byte.
        w_waddr = r_waddr + ADDR_W'(1);
        if (r_off == OFF_LAST) begin
          w_state = ST_COPY_LAST;
        end else begin
          w_raddr = r_raddr + ADDR_W'(1);
          w_off   = r_off + OFF_W'(1);
        end
      end
      ST_COPY_LAST: begin
        w_state = ST_IDLE;
        w_we    = 1'b0;
        w_ready = 1'b1;
        w_copy  = 1'b0;
      end
      default: begin
        w_state = ST_IDLE;
        w_we    = 1'b0;
        w_ready = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_work  <= 2'd2;
      r_front <= 2'd2;
      r_back  <= 2'd1;
      r_raddr <= '0;
      r_waddr <= '0;
      r_off   <= '0;
      r_fill  <= '0;
      r_copy  <= 1'b0;
      r_we    <= 1'b0;
      r_ready <= 1'b1;
      r_blit  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_work  <= w_work;
      r_front <= w_front;
      r_back  <= w_back;
      r_raddr <= w_raddr;
      r_waddr <= w_waddr;
      r_off   <= w_off;
      r_fill  <= w_fill;
      r_copy  <= w_copy;
      r_we    <= w_we;
      r_ready <= w_ready;
      r_blit  <= w_blit;
    end
  end

  // Copy data comes straight from the RAM's one-cycle read so write n pairs with read n.
  assign bus.mem_wdata = r_copy ? bus.mem_rdata : r_fill;
  assign bus.cmd_ready = r_ready;
  assign bus.mem_raddr = r_raddr;
  assign bus.mem_waddr = r_waddr;
  assign bus.mem_we    = r_we;
  assign front_page    = r_front;
  assign work_page     = r_work;
  assign blit_pulse    = r_blit;

endmodule

// File: tb/tb_vm_video_page_engine.sv
// Self-checking bench for vm_video_page_engine with a behavioural framebuffer and pointer model.
module tb_vm_video_page_engine;
  import vm_video_page_engine_pkg::*;

  localparam int FB_BYTES = 4 * PAGE_BYTES;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] front_page;
  logic [1:0] work_page;
  logic       blit_pulse;

  vm_video_page_engine_if bus ();

  vm_video_page_engine dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .front_page (front_page),
    .work_page  (work_page),
    .blit_pulse (blit_pulse)
  );

  always #5 clk = ~clk;

  logic [7:0] fb      [FB_BYTES];
  logic [7:0] ref_mem [FB_BYTES];
  logic [7:0] rdata_r = 8'h00;
  logic       do_load = 1'b0;

  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < FB_BYTES; i++) fb[i] <= 8'(i);
    end else if (bus.mem_we && (int'(bus.mem_waddr) < FB_BYTES)) begin
      fb[bus.mem_waddr] <= bus.mem_wdata;
    end
    if (int'(bus.mem_raddr) < FB_BYTES) rdata_r <= fb[bus.mem_raddr];
  end
  assign bus.mem_rdata = rdata_r;

  int n_cmp  = 0;
  int n_fail = 0;
  int m_work, m_front, m_back;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [1:0] exp_front;
    logic [1:0] exp_work;
  } vec_t;
  vec_t vecs [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int mres(input logic [7:0] p);
    if (p == 8'hFE) return m_front;
    if (p == 8'hFF) return m_back;
    return int'(p % 8'd4);
  endfunction

  task automatic model_cmd(input logic [1:0] op, input logic [7:0] a);
    int t;
    if (op == OP_SELECT) m_work = mres(a);
    else if (op == OP_BLIT) begin
      if (a == 8'hFF) begin
        t = m_front; m_front = m_back; m_back = t;
      end else if (a != 8'hFE) m_front = mres(a);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    m_work = 2; m_front = 2; m_back = 1;
  endtask

  task automatic mem_compare(input string name);
    int diffs = 0;
    for (int i = 0; i < FB_BYTES; i++) if (fb[i] !== ref_mem[i]) diffs++;
    check(name, diffs, 0);
  endtask

  // Watches one fill/copy from the cycle after accept until the engine is ready again.
  task automatic run_busy(input int wbase, input bit chk_data, input logic [7:0] wdat,
                          input int inj, output int busy, output int nw, output int first_w,
                          output int bad, output int bp);
    int ea;
    busy = 0; nw = 0; first_w = -1; bad = 0; bp = 0; ea = wbase;
    for (int c = 1; c <= 40000; c++) begin
      if (bus.cmd_ready) break;
      busy++;
      if (bus.mem_we) begin
        if (first_w < 0) first_w = c;
        if (int'(bus.mem_waddr) != ea || (chk_data && bus.mem_wdata !== wdat)) bad++;
        ea++;
        nw++;
      end else if (nw > 0) bad++;
      if (blit_pulse) bp++;
      if (c == inj) begin
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_BLIT; bus.cmd_a = 8'hFF; bus.cmd_b = 8'h00;
      end
      if (c == inj + 1) bus.cmd_valid = 1'b0;
      tick();
    end
    check("busy_ends_ready", 32'(bus.cmd_ready), 1);
    check("idle_we_low", 32'(bus.mem_we), 0);
  endtask

  // Starts a fill/copy and pulls reset so that the edge ending cycle k resets the engine.
  task automatic abort_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int k);
    int src, dst, lo, oor;
    logic [7:0] col;
    src = mres(a);
    dst = (op == OP_FILL) ? src : mres(b);
    lo  = dst * PAGE_BYTES;
    col = {b[3:0], b[3:0]};
    oor = 0;
    issue(op, a, b);
    if (op == OP_COPY) check("copy_first_raddr", 32'(bus.mem_raddr), src * PAGE_BYTES);
    for (int c = 1; c <= k; c++) begin
      if (bus.mem_we && (int'(bus.mem_waddr) < lo || int'(bus.mem_waddr) >= lo + PAGE_BYTES)) oor++;
      if (bus.cmd_ready) oor++;
      if (c == k) begin
        check("abort_last_waddr", 32'(bus.mem_waddr), lo + k - ((op == OP_FILL) ? 1 : 2));
        reset = 1'b0;
      end
      tick();
    end
    reset = 1'b1;
    check("abort_we", 32'(bus.mem_we), 0);
    check("abort_ready", 32'(bus.cmd_ready), 1);
    check("abort_front", 32'(front_page), 2);
    check("abort_work", 32'(work_page), 2);
    check("abort_write_range", oor, 0);
    if (op == OP_FILL) begin
      for (int n = 0; n < k; n++) ref_mem[lo + n] = col;
    end else begin
      for (int n = 0; n < k - 1; n++) ref_mem[lo + n] = ref_mem[src * PAGE_BYTES + n];
    end
    m_work = 2; m_front = 2; m_back = 1;
    mem_compare("abort_mem");
  endtask

  initial begin
    int busy, nw, first_w, bad, bp;
    logic [1:0] op;
    logic [7:0] a, b;

    vecs[0]  = '{OP_BLIT,   8'hFF, 2'd1, 2'd2};
    vecs[1]  = '{OP_BLIT,   8'hFF, 2'd2, 2'd2};
    vecs[2]  = '{OP_SELECT, 8'h42, 2'd2, 2'd2};
    vecs[3]  = '{OP_SELECT, 8'h01, 2'd2, 2'd1};
    vecs[4]  = '{OP_SELECT, 8'hFE, 2'd2, 2'd2};
    vecs[5]  = '{OP_SELECT, 8'hFF, 2'd2, 2'd1};
    vecs[6]  = '{OP_BLIT,   8'h03, 2'd3, 2'd1};
    vecs[7]  = '{OP_BLIT,   8'hFE, 2'd3, 2'd1};
    vecs[8]  = '{OP_BLIT,   8'hFF, 2'd1, 2'd1};
    vecs[9]  = '{OP_SELECT, 8'hFF, 2'd1, 2'd3};
    vecs[10] = '{OP_BLIT,   8'h86, 2'd2, 2'd3};
    vecs[11] = '{OP_SELECT, 8'hFE, 2'd2, 2'd2};
    vecs[12] = '{OP_BLIT,   8'hFF, 2'd3, 2'd2};
    vecs[13] = '{OP_SELECT, 8'hFF, 2'd3, 2'd2};

    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_a = 8'h00; bus.cmd_b = 8'h00;
    reset = 1'b0;
    tick();
    do_load = 1'b1;
    tick();
    do_load = 1'b0;
    for (int i = 0; i < FB_BYTES; i++) ref_mem[i] = 8'(i);

    check("rst_ready", 32'(bus.cmd_ready), 1);
    check("rst_we", 32'(bus.mem_we), 0);
    check("rst_raddr", 32'(bus.mem_raddr), 0);
    check("rst_waddr", 32'(bus.mem_waddr), 0);
    check("rst_wdata", 32'(bus.mem_wdata), 0);
    check("rst_blit", 32'(blit_pulse), 0);
    check("rst_front", 32'(front_page), 2);
    check("rst_work", 32'(work_page), 2);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].op, vecs[i].a, 8'h00);
      check($sformatf("vec%0d_front", i), 32'(front_page), 32'(vecs[i].exp_front));
      check($sformatf("vec%0d_work", i), 32'(work_page), 32'(vecs[i].exp_work));
      check($sformatf("vec%0d_blit", i), 32'(blit_pulse), (vecs[i].op == OP_BLIT) ? 1 : 0);
      check($sformatf("vec%0d_ready", i), 32'(bus.cmd_ready), 1);
      tick();
      check($sformatf("vec%0d_blit_drop", i), 32'(blit_pulse), 0);
    end

    do_reset();
    issue(OP_FILL, 8'hFE, 8'h05);
    run_busy(2 * PAGE_BYTES, 1'b1, 8'h55, 100, busy, nw, first_w, bad, bp);
    check("fill_busy_cycles", busy, PAGE_BYTES);
    check("fill_writes", nw, PAGE_BYTES);
    check("fill_first_write", first_w, 1);
    check("fill_addr_data", bad, 0);
    check("fill_blit_ignored_pulse", bp, 0);
    check("fill_blit_ignored_front", 32'(front_page), 2);
    for (int n = 0; n < PAGE_BYTES; n++) ref_mem[2 * PAGE_BYTES + n] = 8'h55;
    mem_compare("fill_mem");

    issue(OP_COPY, 8'h03, 8'h00);
    check("copy_first_raddr", 32'(bus.mem_raddr), 3 * PAGE_BYTES);
    run_busy(0, 1'b0, 8'h00, 0, busy, nw, first_w, bad, bp);
    check("copy_busy_cycles", busy, PAGE_BYTES + 1);
    check("copy_writes", nw, PAGE_BYTES);
    check("copy_first_write", first_w, 2);
    check("copy_addr", bad, 0);
    for (int n = 0; n < PAGE_BYTES; n++) ref_mem[n] = ref_mem[3 * PAGE_BYTES + n];
    mem_compare("copy_mem");

    issue(OP_SELECT, 8'h42, 8'h00);
    model_cmd(OP_SELECT, 8'h42);
    check("sel42_work", 32'(work_page), 2);
    abort_op(OP_COPY, 8'h41, 8'hFF, 1500);

    issue(OP_BLIT, 8'hFF, 8'h00);
    issue(OP_SELECT, 8'h03, 8'h00);
    model_cmd(OP_BLIT, 8'hFF);
    model_cmd(OP_SELECT, 8'h03);
    check("prefill_front", 32'(front_page), 1);
    check("prefill_work", 32'(work_page), 3);
    abort_op(OP_FILL, 8'h00, 8'h0A, 1000);
    issue(OP_BLIT, 8'hFF, 8'h00);
    model_cmd(OP_BLIT, 8'hFF);
    check("post_reset_back", 32'(front_page), 1);

    for (int it = 0; it < 40; it++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: a = 8'($urandom_range(0, 3));
        1: a = 8'hFE;
        2: a = 8'hFF;
        default: a = 8'($urandom_range(0, 255));
      endcase
      case ($urandom_range(0, 2))
        0: b = 8'hFE;
        1: b = 8'hFF;
        default: b = 8'($urandom_range(0, 255));
      endcase
      if (op == OP_FILL || op == OP_COPY) begin
        abort_op(op, a, b, int'($urandom_range(3, 400)));
      end else begin
        issue(op, a, b);
        model_cmd(op, a);
        check("rnd_front", 32'(front_page), m_front);
        check("rnd_work", 32'(work_page), m_work);
        check("rnd_blit", 32'(blit_pulse), (op == OP_BLIT) ? 1 : 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vm_video_page_engine.md
# vm_video_page_engine

Downstream executor for the VM CPU's video-page opcodes (selectVideoPage, fillVideoPage, copyVideoPage, blitFrameBuffer). It owns the work/front/back page pointers and drives the 4-page, 4bpp framebuffer RAM for fills and page copies. It exposes the current front page to the scanout path.

## Interface
- PAGE_BYTES, 32000: bytes per page (320×200 pixels, 2 pixels/byte, high nibble = left pixel).
- ADDR_W, 17: framebuffer byte-address width (4 × PAGE_BYTES ≤ 2^17).

- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command strobe from CPU.
- cmd_ready  out  1  engine idle, command accepted on cmd_valid && cmd_ready.
- cmd_op  in  2  0 = select, 1 = fill, 2 = copy, 3 = blit.
- cmd_a  in  8  page id (select/fill/blit) or source page (copy).
- cmd_b  in  8  colour in [3:0] (fill) or destination page (copy).
- mem_raddr  out  ADDR_W  framebuffer read address; data returns one cycle later.
- mem_rdata  in  8  read data.
- mem_waddr  out  ADDR_W  write address.
- mem_wdata  out  8  write data.
- mem_we  out  1  write enable.
- front_page  out  2  page shown by scanout.
- blit_pulse  out  1  one-cycle strobe on each accepted blit.

## Operation
- Page resolve `res(p)`: p ≤ 3 gives p. 0xFE gives front. 0xFF gives back. Any other value gives p[1:0].
- Registers: work, front, back (2 bits each).
- select: work ← res(cmd_a). Completes in the accept cycle with no memory access.
- blit, depending on cmd_a:
  - cmd_a == 0xFE: no pointer change.
  - cmd_a == 0xFF: swap front and back.
  - Otherwise: front ← res(cmd_a).
  - blit_pulse is high the cycle after accept. Completes with no memory access.
- fill: write {cmd_b[3:0], cmd_b[3:0]} to bytes 0..PAGE_BYTES−1 of res(cmd_a), ascending, one byte per cycle.
- copy: stream every byte of res(cmd_a) into res(cmd_b), ascending, pipelined:
  - read offset n at cycle t, write offset n at cycle t+1.
  - src == dst runs normally (idempotent).
  - No vertical-scroll support: bits 7:2 of cmd_a < 0xFE are ignored.
- Page ids are resolved against pointer values at accept time and latched.
- Byte address = page × PAGE_BYTES + offset.
- FSM states:
  - IDLE: cmd_ready = 1. Executes select/blit in place. Goes to FILL or COPY_RD on fill/copy.
  - FILL: one write per cycle. At offset PAGE_BYTES−1 goes to IDLE.
  - COPY_RD: issues read 0, then goes to COPY.
  - COPY: write n while reading n+1. After the last read, goes to COPY_LAST.
  - COPY_LAST: final write, then goes to IDLE.
- Offset counter is 15 bits. It is compared against PAGE_BYTES−1 and never wraps into the next page.

## Timing
- Reset values: cmd_ready = 1, mem_we = 0, mem_raddr = 0, mem_waddr = 0, mem_wdata = 0, blit_pulse = 0, work = 2, front = 2, back = 1, state = IDLE.
- select/blit: new pointer values are visible the cycle after accept. cmd_ready stays 1.
- fill:
  - First write in the cycle after accept, last write PAGE_BYTES cycles after accept.
  - cmd_ready returns to 1 the cycle after the last write.
- copy:
  - First read the cycle after accept, first write 2 cycles after accept, last write PAGE_BYTES+1 cycles after accept.
  - cmd_ready returns to 1 the next cycle.
- cmd_valid while busy is ignored. The CPU must hold it until accepted.
- Reset asserted mid-fill/copy: next cycle is IDLE with mem_we = 0. The partially written page is left as-is.
- Outputs are registered. mem_we is never high in IDLE.

## Structure
- Shared package (used with the CPU): cmd_op encodings, page alias constants 0xFE/0xFF, PAGE_BYTES.
- One sub-module: `vm_page_resolve`, a combinational res(p) mapping instantiated twice (cmd_a, cmd_b).
- Framebuffer RAM lives outside this block (simple dual-port, 1-cycle read).

## Test plan
- After reset: front_page = 2, cmd_ready = 1. Blit 0xFF → front_page = 1, blit_pulse high one cycle. Blit 0xFF again → front_page = 2.
- Fill page 0xFE with 0x5 (front = 2) → 32000 writes of 0x55 at addresses 64000..95999, contiguous mem_we. cmd_ready low exactly 32000 cycles.
- Preload page 3 with incrementing pattern, copy 3 → 0 → page 0 bytes equal page 3 bytes. First write 2 cycles after accept, busy PAGE_BYTES+1 cycles.
- Select 0x42 then copy 0x41 → 0xFF → work = 2, source page 1, dest = back = 1. Result unchanged data, no write outside 32000..63999.
- Reset low at fill offset 1000 → mem_we = 0 the next cycle, cmd_ready = 1, pointers back to 2/2/1, bytes ≥ 1000 untouched.
- cmd_valid pulsed with a blit during a fill → ignored: front_page unchanged, no blit_pulse.
